// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: checks EX memory commands, drives a ready/valid data port,
// steers store lanes and extends load results, with a bus-timeout abort.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data,
    output logic        done,
    output logic        fault,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      r_state;
    logic        r_memReq;
    logic        r_memWe;
    logic [31:0] r_memAddr;
    logic [31:0] r_memWdata;
    logic [3:0]  r_memWstrb;
    logic [31:0] r_loadData;
    logic        r_done;
    logic        r_fault;
    logic        r_isLoad;
    logic        r_unsigned;
    logic [1:0]  r_size;
    logic [1:0]  r_offset;
    logic [31:0] r_toCnt;

    logic        w_anyCmd;
    logic        w_funcOk;
    logic        w_aligned;
    logic        w_legal;
    logic        w_illegal;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadExt;
    logic [31:0] w_cntNext;
    logic        w_timeout;

    // A command with both load and store set is a conflict and counts as illegal.
    always_comb begin
        w_anyCmd = start & (is_load | is_store);
        w_funcOk = 1'b0;
        if (is_load)
            w_funcOk = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else
            w_funcOk = funct3 inside {3'b000, 3'b001, 3'b010};
        case (funct3[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~addr[0];
            2'b10:   w_aligned = (addr[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
        w_legal   = w_anyCmd & ~(is_load & is_store) & w_funcOk & w_aligned;
        w_illegal = w_anyCmd & ~w_legal;
    end

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                w_wdata = {4{store_data[7:0]}};
                w_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{store_data[15:0]}};
                w_wstrb = 4'b0011 << addr[1:0];
            end
            default: begin
                w_wdata = store_data;
                w_wstrb = 4'b1111;
            end
        endcase
        if (is_load)
            w_wstrb = 4'b0000;
    end

    always_comb begin
        case (r_offset)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_size)
            2'b00:   w_loadExt = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_loadExt = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_loadExt = mem_rdata;
        endcase
    end

    assign w_cntNext = r_toCnt + 32'd1;
    assign w_timeout = (TIMEOUT != 0) && (w_cntNext == TIMEOUT);

    // mem_ready on the timeout edge wins, so completion is checked first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= 32'd0;
            r_memWdata <= 32'd0;
            r_memWstrb <= 4'd0;
            r_loadData <= 32'd0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
            r_isLoad   <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'd0;
            r_offset   <= 2'd0;
            r_toCnt    <= 32'd0;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_legal) begin
                        r_state    <= REQ;
                        r_memReq   <= 1'b1;
                        r_memWe    <= is_store;
                        r_memAddr  <= {addr[31:2], 2'b00};
                        r_memWdata <= w_wdata;
                        r_memWstrb <= w_wstrb;
                        r_isLoad   <= is_load;
                        r_unsigned <= funct3[2];
                        r_size     <= funct3[1:0];
                        r_offset   <= addr[1:0];
                        r_toCnt    <= 32'd0;
                    end else if (w_illegal) begin
                        r_fault <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        r_memReq <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= RESP;
                        if (r_isLoad)
                            r_loadData <= w_loadExt;
                    end else if (w_timeout) begin
                        r_memReq <= 1'b0;
                        r_fault  <= 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        r_toCnt <= w_cntNext;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req   = r_memReq;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign mem_wstrb = r_memWstrb;
    assign load_data = r_loadData;
    assign done      = r_done;
    assign fault     = r_fault;
    assign stall     = ((r_state == IDLE) & w_legal) | (r_state == REQ);

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed plan items plus randomized
// accesses compared against an arithmetic model of the load/store rules.
module tb_lsu_mem_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic        done;
    logic        fault;
    logic        stall;

    int          passCount = 0;
    int          checkCount = 0;
    logic [31:0] expLoad = 32'd0;

    lsu_mem_stage #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .load_data  (load_data),
        .done       (done),
        .fault      (fault),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic s, input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd);
        start      = s;
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
    endtask

    function automatic int accessBytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic modelLegal(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a);
        int nb;
        nb = accessBytes(f3);
        if (ld == st) return 1'b0;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        return (a % nb) == 0;
    endfunction

    function automatic logic [31:0] modelStrb(input logic ld, input logic [2:0] f3, input logic [31:0] a);
        int m;
        if (ld) return 32'd0;
        m = ((1 << accessBytes(f3)) - 1) << (a % 4);
        return 32'(m & 15);
    endfunction

    // Each lane repeats the low bytes of the store data with the access size as period.
    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        int nb;
        nb = accessBytes(f3);
        w = 32'd0;
        for (int i = 0; i < 4; i++)
            w = w | (((sd >> (8 * (i % nb))) & 32'hFF) << (8 * i));
        return w;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        logic [31:0] mask;
        int nb;
        nb = accessBytes(f3);
        v = rd >> (8 * (a % 4));
        if (nb < 4) begin
            mask = (32'd1 << (8 * nb)) - 32'd1;
            v = v & mask;
            if (!f3[2] && v[8 * nb - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    // One complete command: readyAt is the REQ cycle on which mem_ready is raised, >TO means never.
    task automatic doAccess(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] rd, input int readyAt);
        logic ok;
        logic fin;
        ok = modelLegal(ld, st, f3, a);
        applyStimulus(1'b1, ld, st, f3, a, sd);
        #1;
        checkOutput("stall_cmd", 32'(stall), 32'(ok));
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        if (!ok) begin
            checkOutput("fault_illegal", 32'(fault), (ld | st) ? 32'd1 : 32'd0);
            checkOutput("req_illegal", 32'(mem_req), 32'd0);
            checkOutput("done_illegal", 32'(done), 32'd0);
            step();
            checkOutput("fault_oneshot", 32'(fault), 32'd0);
            return;
        end
        fin = 1'b0;
        for (int k = 1; k <= int'(TO) && !fin; k++) begin
            checkOutput("req_held", 32'(mem_req), 32'd1);
            checkOutput("stall_req", 32'(stall), 32'd1);
            if (k == 1 || k == readyAt) begin
                checkOutput("mem_addr", mem_addr, {a[31:2], 2'b00});
                checkOutput("mem_we", 32'(mem_we), 32'(st));
                checkOutput("mem_wstrb", 32'(mem_wstrb), modelStrb(ld, f3, a));
                if (st) checkOutput("mem_wdata", mem_wdata, modelWdata(f3, sd));
            end
            mem_ready = (k == readyAt);
            mem_rdata = rd;
            step();
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (k == readyAt) begin
                fin = 1'b1;
                if (ld) expLoad = modelLoad(f3, a, rd);
                checkOutput("done_pulse", 32'(done), 32'd1);
                checkOutput("fault_on_done", 32'(fault), 32'd0);
                checkOutput("req_dropped", 32'(mem_req), 32'd0);
                checkOutput("stall_resp", 32'(stall), 32'd0);
                checkOutput("load_data", load_data, expLoad);
                step();
                checkOutput("done_oneshot", 32'(done), 32'd0);
                checkOutput("load_hold", load_data, expLoad);
            end else if (k == int'(TO)) begin
                checkOutput("fault_timeout", 32'(fault), 32'd1);
                checkOutput("req_timeout", 32'(mem_req), 32'd0);
                checkOutput("done_timeout", 32'(done), 32'd0);
                step();
                checkOutput("fault_to_oneshot", 32'(fault), 32'd0);
                checkOutput("done_to_never", 32'(done), 32'd0);
            end
        end
    endtask

    initial begin
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        int          sel;

        rst = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        step();
        step();
        checkOutput("rst_req", 32'(mem_req), 32'd0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_addr", mem_addr, 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        checkOutput("rst_wstrb", 32'(mem_wstrb), 32'd0);
        checkOutput("rst_load", load_data, 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        step();

        doAccess(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1);
        doAccess(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1);
        doAccess(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 2);
        doAccess(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h12F03456, 1);
        doAccess(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h12F03456, 1);
        doAccess(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h12F03456, 3);
        doAccess(1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 32'h0000_9ABC, 1);
        doAccess(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1);
        doAccess(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 1);
        doAccess(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1);
        doAccess(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 32'h0, 1);
        doAccess(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1);
        doAccess(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1);
        doAccess(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, int'(TO) + 1);
        doAccess(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, int'(TO));

        // Reset during the second REQ cycle aborts silently.
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 32'h400, 32'h11112222);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        checkOutput("abort_req1", 32'(mem_req), 32'd1);
        step();
        checkOutput("abort_req2", 32'(mem_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expLoad = 32'd0;
        checkOutput("abort_req_drop", 32'(mem_req), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_fault", 32'(fault), 32'd0);
        checkOutput("abort_load", load_data, 32'd0);
        step();
        checkOutput("abort_done2", 32'(done), 32'd0);
        checkOutput("abort_fault2", 32'(fault), 32'd0);
        doAccess(1'b0, 1'b1, 3'b010, 32'h100, 32'h0BADCAFE, 32'h0, 1);

        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            ld = (sel == 0) || (sel >= 2 && sel <= 5);
            st = (sel == 0) || (sel >= 6);
            if (sel == 1) begin
                ld = 1'b0;
                st = 1'b0;
            end
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(accessBytes(f3) - 1);
            doAccess(ld, st, f3, a, $urandom, $urandom, $urandom_range(1, int'(TO) + 1));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
